// File: rtl/load_exec_unit.sv
// load_exec_unit: issues one ready load RS entry to memory, broadcasts the data on the CDB, then frees the entry.
// Optional macro LDU_PERF_CNT_EN builds the perf_loads/perf_stall counters (tied to 0 otherwise).
module load_exec_unit #(
  parameter int NUM_ENT  = 3,
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int TAG_BASE = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_ENT-1:0]        ready_bus,
  input  logic [NUM_ENT*ADDR_W-1:0] load_addr,
  output logic                      mem_req,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic                      mem_valid,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      cdb_req,
  input  logic                      cdb_grant,
  output logic [3:0]                cdb_id_out,
  output logic [DATA_W-1:0]         cdb_data_out,
  output logic                      free_tag_flag,
  output logic [3:0]                free_this_tag,
  output logic [31:0]               perf_loads,
  output logic [31:0]               perf_stall
);
  localparam int IDX_W = $clog2(NUM_ENT);
  typedef enum logic [1:0] {IDLE, MEM, CDB, BCAST} state_t;
  state_t             r_state, w_state_nx;
  logic [IDX_W-1:0]   r_idx, w_idx_nx, w_sel;
  logic [ADDR_W-1:0]  r_addr, w_addr_nx;
  logic [DATA_W-1:0]  r_data, w_data_nx;
  logic [3:0]         w_tag;
  logic               w_bcast;
  // ready_bus MSB is entry 0; scanning upward lets the lowest index win
  always_comb begin
    w_sel = '0;
    for (int k = NUM_ENT - 1; k >= 0; k--)
      if (ready_bus[NUM_ENT-1-k]) w_sel = IDX_W'(k);
  end
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_addr_nx  = r_addr;
    w_data_nx  = r_data;
    case (r_state)
      IDLE:
        if (|ready_bus) begin
          w_state_nx = MEM;
          w_idx_nx   = w_sel;
          w_addr_nx  = load_addr[w_sel*ADDR_W +: ADDR_W];
        end
      MEM:
        if (mem_valid) begin
          w_state_nx = CDB;
          w_data_nx  = mem_rdata;
        end
      CDB:     w_state_nx = cdb_grant ? BCAST : CDB;
      BCAST:   w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end
  assign w_tag    = 4'(TAG_BASE) + 4'(r_idx);
  assign w_bcast  = (w_state_nx == BCAST);
  assign mem_addr = r_addr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_addr        <= '0;
      r_data        <= '0;
      mem_req       <= 1'b0;
      cdb_req       <= 1'b0;
      cdb_id_out    <= '0;
      cdb_data_out  <= '0;
      free_tag_flag <= 1'b0;
      free_this_tag <= '0;
    end else begin
      r_state       <= w_state_nx;
      r_idx         <= w_idx_nx;
      r_addr        <= w_addr_nx;
      r_data        <= w_data_nx;
      mem_req       <= (w_state_nx == MEM);
      cdb_req       <= (w_state_nx == CDB);
      cdb_id_out    <= w_bcast ? w_tag : '0;
      cdb_data_out  <= w_bcast ? r_data : '0;
      free_tag_flag <= w_bcast;
      free_this_tag <= w_bcast ? w_tag : '0;
    end
  end
`ifdef LDU_PERF_CNT_EN
  logic [31:0] r_perf_loads, r_perf_stall;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_loads <= '0;
      r_perf_stall <= '0;
    end else begin
      if (r_state == BCAST) r_perf_loads <= r_perf_loads + 32'd1;
      if (r_state == CDB && !cdb_grant) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end
  assign perf_loads = r_perf_loads;
  assign perf_stall = r_perf_stall;
`else
  assign perf_loads = '0;
  assign perf_stall = '0;
`endif
endmodule

// File: tb/tb_load_exec_unit.sv
// tb_load_exec_unit: directed vector table plus hand sequences for stalls, reset abort and mid-MEM ready changes.
module tb_load_exec_unit;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   ready_bus;
  logic [191:0] load_addr;
  logic         mem_req;
  logic [63:0]  mem_addr;
  logic         mem_valid;
  logic [63:0]  mem_rdata;
  logic         cdb_req;
  logic         cdb_grant;
  logic [3:0]   cdb_id_out;
  logic [63:0]  cdb_data_out;
  logic         free_tag_flag;
  logic [3:0]   free_this_tag;
  logic [31:0]  perf_loads;
  logic [31:0]  perf_stall;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic [2:0]  rb;
    logic [63:0] a0, a1, a2, rdata;
    logic [2:0]  rb_after;
    int          mdly, gdly;
    logic [3:0]  etag;
    logic [63:0] eaddr;
  } vec_t;
  vec_t vecs[6];
  load_exec_unit dut (
    .clk(clk), .rst_n(rst_n), .ready_bus(ready_bus), .load_addr(load_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_id_out(cdb_id_out), .cdb_data_out(cdb_data_out),
    .free_tag_flag(free_tag_flag), .free_this_tag(free_this_tag),
    .perf_loads(perf_loads), .perf_stall(perf_stall)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_quiet(input string name);
    chk({name, "_ctl"}, {55'd0, mem_req, cdb_req, free_tag_flag, cdb_id_out, free_this_tag != 4'd0},
        64'd0);
    chk({name, "_bus"}, cdb_data_out | {60'd0, free_this_tag}, 64'd0);
  endtask
  task automatic do_load(input vec_t v);
    ready_bus = v.rb;
    load_addr = {v.a2, v.a1, v.a0};
    step();
    chk("issue_req", {63'd0, mem_req}, 64'd1);
    chk("issue_addr", mem_addr, v.eaddr);
    for (int i = 0; i < v.mdly; i++) begin
      mem_valid = 1'b0;
      step();
      chk("mem_hold_req", {63'd0, mem_req}, 64'd1);
      chk("mem_hold_addr", mem_addr, v.eaddr);
    end
    mem_valid = 1'b1;
    mem_rdata = v.rdata;
    step();
    mem_valid = 1'b0;
    mem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
    chk("mem_drop", {62'd0, mem_req, cdb_req}, 64'd1);
    for (int i = 0; i < v.gdly; i++) begin
      cdb_grant = 1'b0;
      step();
      chk("cdb_hold_req", {63'd0, cdb_req}, 64'd1);
      chk("cdb_hold_id", {60'd0, cdb_id_out}, 64'd0);
    end
    cdb_grant = 1'b1;
    step();
    cdb_grant = 1'b0;
    chk("bcast_req", {62'd0, cdb_req, free_tag_flag}, 64'd1);
    chk("bcast_id", {60'd0, cdb_id_out}, {60'd0, v.etag});
    chk("bcast_data", cdb_data_out, v.rdata);
    chk("bcast_free", {60'd0, free_this_tag}, {60'd0, v.etag});
    ready_bus = v.rb_after;
    step();
    chk_quiet("post_bcast");
  endtask
  initial begin
    vecs[0] = '{3'b100, 64'h1000, 64'h0, 64'h0, 64'hDEAD, 3'b000, 0, 0, 4'd6, 64'h1000};
    vecs[1] = '{3'b011, 64'h0, 64'h20, 64'h30, 64'h1111, 3'b001, 0, 0, 4'd7, 64'h20};
    vecs[2] = '{3'b001, 64'h0, 64'h20, 64'h30, 64'h2222, 3'b000, 0, 0, 4'd8, 64'h30};
    vecs[3] = '{3'b111, 64'hA0, 64'hB0, 64'hC0, 64'hFFFF_FFFF_FFFF_FFFF, 3'b011, 2, 1, 4'd6, 64'hA0};
    vecs[4] = '{3'b011, 64'hA0, 64'hB0, 64'hC0, 64'h8000_0000_0000_0001, 3'b001, 1, 2, 4'd7, 64'hB0};
    vecs[5] = '{3'b010, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h0123_4567_89AB_CDEF, 3'b000, 0, 0,
                4'd7, 64'hFFFF_FFFF_FFFF_FFF8};
    rst_n = 1'b0;
    ready_bus = 3'b000;
    load_addr = '0;
    mem_valid = 1'b0;
    mem_rdata = '0;
    cdb_grant = 1'b0;
    step();
    step();
    chk_quiet("reset");
    chk("reset_addr", mem_addr, 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_quiet("idle");
      chk("idle_addr", mem_addr, 64'd0);
    end
    foreach (vecs[n]) do_load(vecs[n]);
`ifdef LDU_PERF_CNT_EN
    chk("table_perf_loads", {32'd0, perf_loads}, 64'd6);
    chk("table_perf_stall", {32'd0, perf_stall}, 64'd3);
`else
    chk("table_perf_off", {perf_loads, perf_stall}, 64'd0);
`endif
    ready_bus = 3'b010;
    load_addr = {64'h0, 64'h50, 64'h0};
    step();
    chk("toggle_issue", mem_addr, 64'h50);
    ready_bus = 3'b101;
    load_addr = {64'h77, 64'h99, 64'h66};
    step();
    chk("toggle_hold_addr", mem_addr, 64'h50);
    mem_valid = 1'b1;
    mem_rdata = 64'h5;
    step();
    mem_valid = 1'b0;
    cdb_grant = 1'b1;
    step();
    cdb_grant = 1'b0;
    chk("toggle_tag", {60'd0, cdb_id_out}, 64'd7);
    chk("toggle_free", {60'd0, free_this_tag}, 64'd7);
    ready_bus = 3'b000;
    step();
    ready_bus = 3'b100;
    load_addr = {64'h0, 64'h0, 64'h40};
    step();
    mem_valid = 1'b1;
    mem_rdata = 64'h77;
    step();
    mem_valid = 1'b0;
    ready_bus = 3'b000;
    chk("rst_pre_cdb", {63'd0, cdb_req}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk_quiet("rst_async");
    chk("rst_async_addr", mem_addr, 64'd0);
    step();
    rst_n = 1'b1;
    mem_valid = 1'b1;
    mem_rdata = 64'h1234;
    step();
    mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_quiet("rst_after");
      step();
    end
    do_load('{3'b100, 64'h1000, 64'h0, 64'h0, 64'hBEEF, 3'b000, 5, 3, 4'd6, 64'h1000});
`ifdef LDU_PERF_CNT_EN
    chk("perf_loads", {32'd0, perf_loads}, 64'd1);
    chk("perf_stall", {32'd0, perf_stall}, 64'd3);
`else
    chk("perf_off", {perf_loads, perf_stall}, 64'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
